// File: rtl/hash_table_cmd_queue_if.sv
// Signal bundle between command masters, the command queue and hash_table.
// Latency: none, wiring only.
// Backpressure: cmd_ready / rsp_ready carry the valid-ready flow control.
interface hash_table_cmd_queue_if #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // command channel
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [KEY_WIDTH-1:0]   cmd_key;
    logic [VALUE_WIDTH-1:0] cmd_value;
    // response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_op;
    logic [KEY_WIDTH-1:0]   rsp_key;
    logic [VALUE_WIDTH-1:0] rsp_value;
    logic                   rsp_error;
    logic                   rsp_timeout;
    // hash_table side
    logic [KEY_WIDTH-1:0]   ht_key_in;
    logic [VALUE_WIDTH-1:0] ht_value_in;
    logic [1:0]             ht_op_sel;
    logic                   ht_op_en;
    logic [VALUE_WIDTH-1:0] ht_value_out;
    logic                   ht_op_done;
    logic                   ht_op_error;
    // status
    logic [CW-1:0]          fifo_count;
    logic                   busy;

    // the queue itself
    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
               ht_value_out, ht_op_done, ht_op_error,
        output cmd_ready, rsp_valid, rsp_op, rsp_key, rsp_value, rsp_error, rsp_timeout,
               ht_key_in, ht_value_in, ht_op_sel, ht_op_en, fifo_count, busy
    );

    // command source, response sink and hash_table as seen from outside
    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
               ht_value_out, ht_op_done, ht_op_error,
        input  cmd_ready, rsp_valid, rsp_op, rsp_key, rsp_value, rsp_error, rsp_timeout,
               ht_key_in, ht_value_in, ht_op_sel, ht_op_en, fifo_count, busy
    );
endinterface

// File: rtl/hash_table_cmd_queue.sv
// In-order command FIFO that serialises insert/delete/search requests onto hash_table.
// Latency: command accepted into an empty queue at edge N raises ht_op_en after N+1.
// Backpressure: cmd_ready = !full (no pop bypass); response held until rsp_ready.
module hash_table_cmd_queue #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    hash_table_cmd_queue_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0]    OP_SEARCH  = 2'b10;
    localparam logic [1:0]    OP_ILLEGAL = 2'b11;
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [1:0]             op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, COOL} state_t;

    cmd_t                   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    state_t                 state_q;
    logic [TW-1:0]          tmo_cnt_q;
    logic [KEY_WIDTH-1:0]   ht_key_in_q;
    logic [VALUE_WIDTH-1:0] ht_value_in_q;
    logic [1:0]             ht_op_sel_q;
    logic                   ht_op_en_q;
    logic                   rsp_valid_q;
    logic [1:0]             rsp_op_q;
    logic [KEY_WIDTH-1:0]   rsp_key_q;
    logic [VALUE_WIDTH-1:0] rsp_value_q;
    logic                   rsp_error_q;
    logic                   rsp_timeout_q;

    logic full;
    logic push;
    logic pop;
    cmd_t cmd_in;
    cmd_t head;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign push   = bus.cmd_valid && bus.cmd_ready;
    assign pop    = (state_q == IDLE) && (count_q != '0);
    assign cmd_in = '{op: bus.cmd_op, key: bus.cmd_key, value: bus.cmd_value};
    assign head   = mem_q[rd_ptr_q];

    assign bus.cmd_ready   = rst && !full;
    assign bus.fifo_count  = count_q;
    assign bus.busy        = (state_q != IDLE) || (count_q != '0);
    assign bus.ht_key_in   = ht_key_in_q;
    assign bus.ht_value_in = ht_value_in_q;
    assign bus.ht_op_sel   = ht_op_sel_q;
    assign bus.ht_op_en    = ht_op_en_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_op      = rsp_op_q;
    assign bus.rsp_key     = rsp_key_q;
    assign bus.rsp_value   = rsp_value_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;

    // next-state for FIFO pointers and occupancy; power-of-2 depth wraps naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage: payload needs no reset, only the pointers do
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // issue FSM: one request outstanding, registered hash_table and response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            ht_key_in_q   <= '0;
            ht_value_in_q <= '0;
            ht_op_sel_q   <= '0;
            ht_op_en_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_op_q      <= '0;
            rsp_key_q     <= '0;
            rsp_value_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        rsp_op_q  <= head.op;
                        rsp_key_q <= head.key;
                        if (head.op == OP_ILLEGAL) begin
                            // never reaches hash_table; answered directly
                            rsp_valid_q   <= 1'b1;
                            rsp_error_q   <= 1'b1;
                            rsp_value_q   <= '0;
                            rsp_timeout_q <= 1'b0;
                            state_q       <= RESP;
                        end else begin
                            ht_key_in_q   <= head.key;
                            ht_value_in_q <= head.value;
                            ht_op_sel_q   <= head.op;
                            ht_op_en_q    <= 1'b1;
                            tmo_cnt_q     <= '0;
                            state_q       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.ht_op_done) begin
                        // done has priority over a coincident timeout
                        ht_op_en_q    <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= bus.ht_op_error;
                        rsp_timeout_q <= 1'b0;
                        rsp_value_q   <= (ht_op_sel_q == OP_SEARCH && !bus.ht_op_error)
                                         ? bus.ht_value_out : '0;
                        state_q       <= RESP;
                    end else if (tmo_cnt_q == TO_LAST) begin
                        ht_op_en_q    <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_value_q   <= '0;
                        state_q       <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= COOL;
                    end
                end
                COOL: begin
                    // let hash_table release op_done before the next request
                    if (!bus.ht_op_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_table_cmd_queue.sv
// Randomised bench for hash_table_cmd_queue with a behavioural hash_table and scoreboard.
// Latency: drives and samples once per cycle on the falling clock edge.
// Backpressure: random and directed rsp_ready stalls; random cmd_valid gaps.
module tb_hash_table_cmd_queue;
    localparam int KW    = 32;
    localparam int VW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst;

    hash_table_cmd_queue_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .FIFO_DEPTH(DEPTH)) bus ();

    hash_table_cmd_queue #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // lat: ISSUE cycles before done (0 = never answer); tail: cycles done lingers after op_en drops
    typedef struct { logic [1:0] op; logic [KW-1:0] key; logic [VW-1:0] value; int lat; int tail; bit ferr; } stim_t;
    typedef struct { logic [1:0] op; logic [KW-1:0] key; logic [VW-1:0] value; bit err; bit tmo; } rsp_t;
    typedef struct { logic [1:0] op; logic [KW-1:0] key; logic [VW-1:0] value; int lat; int tail;
                     bit derr; logic [VW-1:0] dval; } fate_t;

    stim_t           stim_q[$];
    rsp_t            exp_q[$];
    fate_t           iss_q[$];
    logic [VW-1:0]   table_m [logic [KW-1:0]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit stall     = 0;
    bit bp_arm    = 0;
    int gap_pct   = 0;
    int ready_pct = 100;

    bit    ht_active = 0;
    bit    done_seen = 0;
    int    ht_cyc    = 0;
    int    tail_left = 0;
    fate_t cur;

    bit   rsp_stalled = 0;
    rsp_t rsp_saved;
    int   bp_left = 0;
    logic [$clog2(DEPTH):0] bp_count;
    int   last_push_cyc  = 0;
    int   last_issue_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] value,
                                 input int lat, input int tail, input bit ferr);
        stim_t s;
        s.op = op; s.key = key; s.value = value; s.lat = lat; s.tail = tail; s.ferr = ferr;
        return s;
    endfunction

    // commands complete in push order, so table effects can be applied at push time
    function automatic void accept(input stim_t s);
        rsp_t  r;
        fate_t f;
        r.op = s.op; r.key = s.key; r.value = '0; r.err = 1'b0; r.tmo = 1'b0;
        if (s.op == 2'b11) begin
            r.err = 1'b1;
        end else begin
            f.op = s.op; f.key = s.key; f.value = s.value; f.lat = s.lat; f.tail = s.tail;
            f.derr = 1'b0; f.dval = $urandom();
            if (s.lat == 0) begin
                r.err = 1'b1; r.tmo = 1'b1;
            end else if (s.ferr) begin
                r.err = 1'b1; f.derr = 1'b1;
            end else begin
                case (s.op)
                    2'b00: table_m[s.key] = s.value;
                    2'b01: if (table_m.exists(s.key)) table_m.delete(s.key);
                           else begin r.err = 1'b1; f.derr = 1'b1; end
                    default: if (table_m.exists(s.key)) begin
                                 r.value = table_m[s.key]; f.dval = table_m[s.key];
                             end else begin
                                 r.err = 1'b1; f.derr = 1'b1;
                             end
                endcase
            end
            iss_q.push_back(f);
        end
        exp_q.push_back(r);
    endfunction

    function automatic void reset_model();
        stim_q.delete(); exp_q.delete(); iss_q.delete(); table_m.delete();
        ht_active = 0; done_seen = 0; tail_left = 0; rsp_stalled = 0; bp_left = 0; bp_arm = 0; stall = 0;
        bus.ht_op_done = 1'b0; bus.ht_op_error = 1'b0;
    endfunction

    task automatic cycle();
        rsp_t got;
        rsp_t e;
        @(negedge clk);
        cyc++;
        // response channel
        if (bus.rsp_valid) begin
            got.op = bus.rsp_op; got.key = bus.rsp_key; got.value = bus.rsp_value;
            got.err = bus.rsp_error; got.tmo = bus.rsp_timeout;
            if (rsp_stalled) begin
                check("rsp_hold_key", got.key, rsp_saved.key);
                check("rsp_hold_val", got.value, rsp_saved.value);
                check("rsp_hold_flags", {got.op, got.err, got.tmo}, {rsp_saved.op, rsp_saved.err, rsp_saved.tmo});
            end
            if (bp_arm && !rsp_stalled) begin
                bp_left = 10; bp_arm = 0; bp_count = bus.fifo_count;
            end
            if (bp_left > 0) begin
                bus.rsp_ready = 1'b0;
                bp_left--;
                check("bp_op_en", bus.ht_op_en, 0);
                check("bp_no_pop", bus.fifo_count, bp_count);
            end else begin
                bus.rsp_ready = ($urandom_range(99) < ready_pct);
            end
            if (bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_op", got.op, e.op);
                    check("rsp_key", got.key, e.key);
                    check("rsp_value", got.value, e.value);
                    check("rsp_error", got.err, e.err);
                    check("rsp_timeout", got.tmo, e.tmo);
                end
            end
            rsp_stalled = !bus.rsp_ready;
            rsp_saved   = got;
        end else begin
            bus.rsp_ready = ($urandom_range(99) < ready_pct);
            rsp_stalled   = 0;
        end
        // behavioural hash_table
        if (!rst) begin
            ht_active = 0; bus.ht_op_done = 1'b0; bus.ht_op_error = 1'b0;
        end else begin
            if (!ht_active && bus.ht_op_en) begin
                if (iss_q.size() == 0) begin
                    check("spurious_issue", 1, 0);
                end else begin
                    cur = iss_q.pop_front();
                    check("issue_op", bus.ht_op_sel, cur.op);
                    check("issue_val", bus.ht_value_in, cur.value);
                    ht_active = 1; ht_cyc = 0; done_seen = 0; last_issue_cyc = cyc;
                end
            end
            if (ht_active) begin
                if (bus.ht_op_en) begin
                    ht_cyc++;
                    check("issue_key", bus.ht_key_in, cur.key);
                    if (!stall && cur.lat != 0 && ht_cyc >= cur.lat) begin
                        bus.ht_op_done = 1'b1; bus.ht_op_error = cur.derr; bus.ht_value_out = cur.dval;
                        done_seen = 1;
                    end
                end else begin
                    if (!done_seen) check("timeout_len", ht_cyc, TMO);
                    ht_active = 0; tail_left = cur.tail;
                end
            end
            if (!ht_active && bus.ht_op_done) begin
                if (tail_left > 0) tail_left--;
                else begin
                    bus.ht_op_done = 1'b0; bus.ht_op_error = 1'b0; bus.ht_value_out = $urandom();
                end
            end
        end
        // command channel
        if (!rst) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'($urandom()); bus.cmd_key = $urandom(); bus.cmd_value = $urandom();
        end else if (stim_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = stim_q[0].op;
            bus.cmd_key   = stim_q[0].key;
            bus.cmd_value = stim_q[0].value;
            if (bus.cmd_ready) begin
                accept(stim_q.pop_front());
                last_push_cyc = cyc;
            end
        end else begin
            bus.cmd_valid = 1'b0; bus.cmd_op = 2'($urandom()); bus.cmd_key = $urandom(); bus.cmd_value = $urandom();
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || ht_active) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", stim_q.size() + exp_q.size() + iss_q.size(), 0);
        repeat (4) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        reset_model();
        repeat (n) cycle();
        check("rst_ht_op_en", bus.ht_op_en, 0);
        check("rst_ht_key", bus.ht_key_in, 0);
        check("rst_ht_val_sel", {bus.ht_value_in, bus.ht_op_sel}, 0);
        check("rst_rsp_flags", {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.rsp_op}, 0);
        check("rst_rsp_key_val", {bus.rsp_key, bus.rsp_value}, 0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_key = '0; bus.cmd_value = '0;
        bus.rsp_ready = 1'b0; bus.ht_op_done = 1'b0; bus.ht_op_error = 1'b0; bus.ht_value_out = '0;
        do_reset(2);

        // single insert into an empty queue: issue one edge after acceptance
        stim_q.push_back(mk(2'b00, 1, 2, 3, 0, 0));
        drain(100);
        check("issue_latency", last_issue_cyc - last_push_cyc, 2);

        // search hit, then search with hash_table error
        stim_q.push_back(mk(2'b00, 19, 4, 1, 0, 0));
        stim_q.push_back(mk(2'b10, 19, 32'h5555, 2, 1, 0));
        stim_q.push_back(mk(2'b10, 1, 32'h7777, 2, 0, 1));
        drain(200);

        // fill the FIFO behind a stalled request; order must be preserved
        stall = 1;
        for (int i = 0; i < 5; i++) stim_q.push_back(mk(2'b00, 3 + 8 * i, 100 + i, 1, 0, 0));
        n = 0;
        while (stim_q.size() != 0 && n < 20) begin cycle(); n++; end
        cycle();
        check("full_count", bus.fifo_count, DEPTH);
        check("full_cmd_ready", bus.cmd_ready, 0);
        check("full_op_en", bus.ht_op_en, 1);
        stall = 0;
        drain(200);

        // response backpressure with a second command queued
        bp_arm = 1;
        stim_q.push_back(mk(2'b00, 40, 1, 1, 0, 0));
        stim_q.push_back(mk(2'b01, 40, 0, 1, 2, 0));
        drain(200);

        // timeout, then an illegal op that must never reach hash_table
        stim_q.push_back(mk(2'b10, 50, 0, 0, 0, 0));
        stim_q.push_back(mk(2'b11, 60, 9, 1, 0, 0));
        drain(200);

        // reset while a request is in ISSUE and two are queued
        stall = 1;
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(2'b00, 70 + i, i, 1, 0, 0));
        n = 0;
        while (!(bus.fifo_count == 2 && bus.ht_op_en) && n < 30) begin cycle(); n++; end
        check("pre_rst_queued", bus.fifo_count, 2);
        do_reset(1);
        stim_q.push_back(mk(2'b00, 9, 99, 2, 0, 0));
        stim_q.push_back(mk(2'b10, 9, 0, 1, 0, 0));
        drain(200);

        // randomised traffic
        gap_pct = 30;
        ready_pct = 70;
        for (int i = 0; i < 200; i++) begin
            stim_q.push_back(mk(($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2)),
                                KW'($urandom_range(7)), $urandom(),
                                ($urandom_range(19) == 0) ? 0 : $urandom_range(4, 1),
                                $urandom_range(2), ($urandom_range(9) == 0)));
        end
        drain(20000);
        check("end_busy", bus.busy, 0);
        check("end_fifo_count", bus.fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_table_cmd_queue.md
Name: hash_table_cmd_queue

Overview:
Upstream command front-end for hash_table. It accepts insert, delete and search requests on a valid/ready interface and buffers them in an in-order FIFO. It issues one request at a time to hash_table using that block's op_en/op_done protocol, then returns each result on a valid/ready response interface. Masters therefore never deal with the level-held op_en handshake.

Parameters:
KEY_WIDTH, 32, key width; must match hash_table
VALUE_WIDTH, 32, value width; must match hash_table
FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2
TIMEOUT_CYCLES, 255, maximum cycles in ISSUE without ht_op_done before the request is aborted; at least 1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on the next clk edge)
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; equals !full, forced 0 while rst=0
cmd_op  in  2  00 insert, 01 delete, 10 search, 11 illegal
cmd_key  in  KEY_WIDTH  command key
cmd_value  in  VALUE_WIDTH  insert value; ignored for other ops
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_op  out  2  op of the completed command
rsp_key  out  KEY_WIDTH  key of the completed command
rsp_value  out  VALUE_WIDTH  search result; 0 for all other ops and for any error
rsp_error  out  1  hash_table op_error, illegal op, or timeout
rsp_timeout  out  1  request was aborted by timeout
ht_key_in  out  KEY_WIDTH  to hash_table key_in
ht_value_in  out  VALUE_WIDTH  to hash_table value_in
ht_op_sel  out  2  to hash_table op_sel
ht_op_en  out  1  to hash_table op_en
ht_value_out  in  VALUE_WIDTH  from hash_table value_out
ht_op_done  in  1  from hash_table op_done
ht_op_error  in  1  from hash_table op_error
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  high when state is not IDLE or fifo_count is nonzero

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - FIFO is emptied; fifo_count=0; state=IDLE.
  - All ht_* outputs = 0; all rsp_* outputs = 0; busy=0.
  - Reset applies mid-operation too: an in-flight request is dropped and produces no response; ht_op_en is low after that edge.
- FIFO push: occurs when cmd_valid && cmd_ready. There is no bypass; cmd_ready is low when full even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, RESP, COOL.
- IDLE, FIFO non-empty, legal op:
  - Pop the head entry.
  - Register key, value and op onto ht_key_in, ht_value_in and ht_op_sel.
  - Set ht_op_en=1 and go to ISSUE.
  - Latency: a command accepted into an empty FIFO at edge N has ht_op_en=1 after edge N+1.
- IDLE, head op is 11: pop it without asserting ht_op_en. Load rsp_error=1, rsp_value=0, rsp_timeout=0 and go to RESP.
- ISSUE:
  - ht_op_en and all ht_* fields are held stable.
  - A timeout counter starts at 0 and increments every cycle.
  - ht_op_done=1 sampled: capture rsp_op, rsp_key, rsp_error=ht_op_error, rsp_value (ht_value_out if op is search and no error, else 0), rsp_timeout=0. Drive ht_op_en=0 and go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: drive ht_op_en=0, set rsp_error=1, rsp_timeout=1, rsp_value=0, and go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1 with all rsp_* fields stable until rsp_ready.
  - On the handshake, rsp_valid drops at the next edge and the state goes to COOL.
  - No new issue happens while in RESP.
- COOL: ht_op_en=0. Stay until ht_op_done=0 is sampled, then go to IDLE. The minimum COOL residence is 1 cycle.
- Minimum per-command turnaround is 4 cycles: pop, done, rsp handshake, COOL.
- cmd_valid while rst=0 is ignored.

Test Plan:
- Single insert, empty queue: cmd op=00 key=1 value=2 accepted at edge N; bench model asserts done 3 cycles later with error=0 -> ht_op_en=1 after N+1 with ht_key_in=1, ht_value_in=2; then rsp_valid=1 with rsp_op=00, rsp_key=1, rsp_error=0, rsp_value=0.
- Search hit: preload model key 19 -> value 4; cmd op=10 key=19 -> rsp_value=4, rsp_error=0. Search of key 1 with model op_error=1 -> rsp_error=1, rsp_value=0.
- Full/order, FIFO_DEPTH=4: model holds done low, push keys 3, 11, 19, 27, 35 back-to-back -> the first is popped into ISSUE, keys 11/19/27/35 fill the FIFO (fifo_count=4), cmd_ready=0. After releasing the model, responses arrive strictly in key order 3, 11, 19, 27, 35.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* fields stable, ht_op_en stays 0, no pop; release -> handshake, then COOL, then the next issue.
- Timeout, TIMEOUT_CYCLES=16: model never asserts done -> ht_op_en drops after 16 ISSUE cycles; response has rsp_error=1, rsp_timeout=1. Illegal op=11 -> ht_op_en never asserted, rsp_error=1, rsp_timeout=0.
- Reset mid-ISSUE with 2 entries queued: drive rst=0 for one edge -> ht_op_en=0, fifo_count=0, rsp_valid=0, busy=0, no response emitted; a subsequent insert completes normally.
